// File: rtl/fft_bfp_scale_ctrl.sv
// Block-floating-point scaling controller: counts samples and overflows per FFT stage,
// decides the /2 rescale of the next stage and accumulates the block exponent.
module fft_bfp_scale_ctrl #(
  parameter int LOG2_N_MAX         = 10,
  parameter int SCALE_FACTOR_WIDTH = 8,
  parameter int STAGE_WIDTH        = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          start_i,
  input  logic [STAGE_WIDTH-1:0]        fft_len_log2_i,
  input  logic                          rescale_mode_i,
  input  logic [7:0]                    threshold_i,
  input  logic                          sample_valid_i,
  input  logic                          overflow_i,
  output logic                          rescale_en_o,
  output logic [STAGE_WIDTH-1:0]        stage_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [SCALE_FACTOR_WIDTH-1:0] block_exp_o,
  output logic [7:0]                    ovf_count_o,
  output logic [LOG2_N_MAX-1:0]         stage_scaled_o,
  output logic [1:0]                    state_o
);

  // Handshake: sample_valid_i is a one-way strobe (no ready). Each high cycle in RUN is
  // one sample; the stage sequencer must hold it low during EVAL, which lasts exactly one
  // cycle after the 2^L-th sample. state_o mirrors the FSM state for debug/checkers.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int                     CNT_W   = LOG2_N_MAX + 1;
  localparam logic [STAGE_WIDTH-1:0] LEN_MAX = STAGE_WIDTH'(LOG2_N_MAX);

  state_t                  state_q;
  state_t                  state_d;
  logic [STAGE_WIDTH-1:0]  len_q;
  logic                    mode_q;
  logic [7:0]              thr_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [STAGE_WIDTH-1:0]  len_clamped;
  logic [7:0]              thr_clamped;
  logic [CNT_W-1:0]        stage_len;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    last_sample;
  logic                    last_stage;
  logic                    scale_next;

  always_comb begin
    len_clamped = fft_len_log2_i;
    if (fft_len_log2_i == '0) begin
      len_clamped = STAGE_WIDTH'(1);
    end else if (fft_len_log2_i > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
    thr_clamped = (threshold_i == 8'd0) ? 8'd1 : threshold_i;
  end

  assign stage_len   = CNT_W'(1) << len_q;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign last_sample = sample_valid_i && (cnt_inc == stage_len);
  assign last_stage  = (stage_o == (len_q - STAGE_WIDTH'(1)));
  assign scale_next  = mode_q | (ovf_count_o >= thr_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (last_sample) state_d = ST_EVAL;
      ST_EVAL: state_d = last_stage ? ST_DONE : ST_RUN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      len_q          <= '0;
      mode_q         <= 1'b0;
      thr_q          <= '0;
      cnt_q          <= '0;
      rescale_en_o   <= 1'b0;
      stage_o        <= '0;
      block_exp_o    <= '0;
      ovf_count_o    <= '0;
      stage_scaled_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_q          <= len_clamped;
            mode_q         <= rescale_mode_i;
            thr_q          <= thr_clamped;
            cnt_q          <= '0;
            rescale_en_o   <= rescale_mode_i;
            stage_o        <= '0;
            block_exp_o    <= '0;
            ovf_count_o    <= '0;
            stage_scaled_o <= '0;
          end
        end
        ST_RUN: begin
          if (sample_valid_i) begin
            cnt_q <= cnt_inc;
            if (overflow_i && (ovf_count_o != 8'hFF)) begin
              ovf_count_o <= ovf_count_o + 8'd1;
            end
          end
        end
        ST_EVAL: begin
          if (rescale_en_o) begin
            if (block_exp_o != '1) begin
              block_exp_o <= block_exp_o + SCALE_FACTOR_WIDTH'(1);
            end
            stage_scaled_o <= stage_scaled_o | (LOG2_N_MAX'(1) << stage_o);
          end
          if (last_stage) begin
            rescale_en_o <= 1'b0;
          end else begin
            // Decision uses the count of the stage just finished, before it is cleared.
            stage_o      <= stage_o + STAGE_WIDTH'(1);
            rescale_en_o <= scale_next;
            ovf_count_o  <= '0;
            cnt_q        <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o  = (state_q == ST_RUN) || (state_q == ST_EVAL);
  assign done_o  = (state_q == ST_DONE);
  assign state_o = state_q;

  a_done_single: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    done_o |=> !done_o);
  a_eval_single: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_q == ST_EVAL) |=> (state_q != ST_EVAL));

endmodule

// File: tb/tb_fft_bfp_scale_ctrl.sv
// Randomized scoreboard bench for fft_bfp_scale_ctrl: a per-transform reference model
// predicts stage-entry and end-of-transform responses; a negedge monitor compares them.
module tb_fft_bfp_scale_ctrl;

  localparam int LMAX  = 10;
  localparam int SFW   = 8;
  localparam int SW    = 4;
  localparam int SEV_W = SW + 1 + 8;
  localparam int DEV_W = SFW + LMAX + SW + 8;

  // clock / reset
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            start_i = 1'b0;
  logic [SW-1:0]   fft_len_log2_i = '0;
  logic            rescale_mode_i = 1'b0;
  logic [7:0]      threshold_i = '0;
  logic            sample_valid_i = 1'b0;
  logic            overflow_i = 1'b0;
  logic            rescale_en_o;
  logic [SW-1:0]   stage_o;
  logic            busy_o;
  logic            done_o;
  logic [SFW-1:0]  block_exp_o;
  logic [7:0]      ovf_count_o;
  logic [LMAX-1:0] stage_scaled_o;
  logic [1:0]      state_o;

  fft_bfp_scale_ctrl #(
    .LOG2_N_MAX(LMAX), .SCALE_FACTOR_WIDTH(SFW), .STAGE_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
    .fft_len_log2_i(fft_len_log2_i), .rescale_mode_i(rescale_mode_i),
    .threshold_i(threshold_i), .sample_valid_i(sample_valid_i),
    .overflow_i(overflow_i), .rescale_en_o(rescale_en_o), .stage_o(stage_o),
    .busy_o(busy_o), .done_o(done_o), .block_exp_o(block_exp_o),
    .ovf_count_o(ovf_count_o), .stage_scaled_o(stage_scaled_o), .state_o(state_o)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [SEV_W-1:0] exp_stage_q[$];
  logic [DEV_W-1:0] exp_done_q[$];
  bit               ovf_pat[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int clamp_len(input int raw);
    if (raw == 0) return 1;
    if (raw > LMAX) return LMAX;
    return raw;
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({rescale_en_o, stage_o, busy_o, done_o, block_exp_o, ovf_count_o,
                stage_scaled_o, state_o});
  endfunction

  // pattern generation
  task automatic gen_pattern(input int lc, input int pct);
    ovf_pat.delete();
    for (int i = 0; i < lc * (1 << lc); i++) ovf_pat.push_back($urandom_range(0, 99) < pct);
  endtask

  task automatic force_stage_count(input int lc, input int s, input int k);
    int n;
    n = 1 << lc;
    for (int i = 0; i < n; i++) ovf_pat[s * n + i] = (i < k);
  endtask

  function automatic int stage_ovf(input int lc, input int s);
    int n;
    int c;
    n = 1 << lc;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(ovf_pat[s * n + i]);
    return (c > 255) ? 255 : c;
  endfunction

  // reference model: scaling decisions per stage from the overflow totals
  task automatic model_push(input int raw_l, input int mode, input int thr, input int abort_stage);
    int lc;
    int th;
    int bexp;
    int c;
    bit en;
    logic [LMAX-1:0] bm;
    lc   = clamp_len(raw_l);
    th   = (thr == 0) ? 1 : thr;
    en   = (mode != 0);
    bexp = 0;
    bm   = '0;
    for (int s = 0; s < lc; s++) begin
      exp_stage_q.push_back({SW'(s), en, 8'd0});
      if (s == abort_stage) break;
      c = stage_ovf(lc, s);
      if (en) begin
        bexp = (bexp == 255) ? 255 : bexp + 1;
        bm[s] = 1'b1;
      end
      if (s == lc - 1) exp_done_q.push_back({SFW'(bexp), bm, SW'(s), 8'(c)});
      else en = (mode != 0) || (c >= th);
    end
  endtask

  // driver
  task automatic run_transform(input int raw_l, input int mode, input int thr,
                               input int gap_min, input int gap_max, input int abort_stage,
                               input bit junk_start, input bit junk_eval);
    int lc;
    int n;
    lc = clamp_len(raw_l);
    n  = 1 << lc;
    model_push(raw_l, mode, thr, abort_stage);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    fft_len_log2_i = SW'(raw_l);
    rescale_mode_i = mode[0];
    threshold_i = 8'(thr);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    fft_len_log2_i = SW'($urandom_range(0, 15));
    rescale_mode_i = 1'($urandom_range(0, 1));
    threshold_i = 8'($urandom_range(0, 255));
    for (int s = 0; s < lc; s++) begin
      for (int i = 0; i < n; i++) begin
        if (s == abort_stage && i == n / 2) begin
          #2 reset_n_i = 1'b0;
          sample_valid_i = 1'b0;
          #1 check("async_reset_outputs", all_outputs(), 64'd0);
          @(posedge clk_i); #3 reset_n_i = 1'b1;
          @(posedge clk_i); #1;
          return;
        end
        sample_valid_i = 1'b1;
        overflow_i = ovf_pat[s * n + i];
        @(posedge clk_i); #1;
        sample_valid_i = 1'b0;
        overflow_i = 1'($urandom_range(0, 1));
        if (i != n - 1) begin
          repeat ($urandom_range(gap_min, gap_max)) begin
            if (junk_start) start_i = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
          end
          start_i = 1'b0;
        end
      end
      check("eval_busy", 64'({busy_o, done_o}), 64'b10);
      check("eval_ovf_count", 64'(ovf_count_o), 64'(stage_ovf(lc, s)));
      if (junk_eval) begin
        sample_valid_i = 1'b1;
        overflow_i = 1'b1;
      end
      @(posedge clk_i); #1;
      sample_valid_i = 1'b0;
      if (s == lc - 1) begin
        check("done_latency", 64'({done_o, busy_o}), 64'b10);
        if (junk_eval) begin
          sample_valid_i = 1'b1;
          overflow_i = 1'b1;
        end
        @(posedge clk_i); #1;
        sample_valid_i = 1'b0;
        check("done_pulse_width", 64'(done_o), 64'd0);
      end
    end
  endtask

  // monitor
  logic prev_busy = 1'b0;
  logic [SW-1:0] prev_stage = '0;
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (busy_o && (!prev_busy || stage_o != prev_stage)) begin
        if (exp_stage_q.size() == 0) check("stage_unexpected", 64'(stage_o), 64'hFFFF);
        else check("stage_entry", 64'({stage_o, rescale_en_o, ovf_count_o}),
                   64'(exp_stage_q.pop_front()));
      end
      if (done_o) begin
        if (exp_done_q.size() == 0) check("done_unexpected", 64'(done_o), 64'd0);
        else check("done_result",
                   64'({block_exp_o, stage_scaled_o, stage_o, ovf_count_o}),
                   64'(exp_done_q.pop_front()));
      end
    end
    prev_busy  <= busy_o;
    prev_stage <= stage_o;
  end

  initial begin
    repeat (95000) @(posedge clk_i);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l;
    int md;
    int th;
    int pct;
    #2 check("reset_outputs", all_outputs(), 64'd0);
    @(posedge clk_i); #3 reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("idle_after_reset", all_outputs(), 64'd0);

    // unconditional scaling every stage
    gen_pattern(3, 0);
    run_transform(3, 1, 1, 0, 0, -1, 1'b0, 1'b0);

    // conditional scaling: 1, 2, 0 overflows with threshold 2
    gen_pattern(3, 0);
    force_stage_count(3, 0, 1);
    force_stage_count(3, 1, 2);
    run_transform(3, 0, 2, 0, 0, -1, 1'b0, 1'b1);

    // saturation of the overflow counter, threshold 0 treated as 1
    gen_pattern(9, 0);
    force_stage_count(9, 0, 300);
    run_transform(9, 0, 0, 0, 0, -1, 1'b0, 1'b0);

    // sparse valids and ignored starts mid-transform
    gen_pattern(2, 0);
    run_transform(2, 0, 1, 2, 2, -1, 1'b1, 1'b1);

    // asynchronous reset mid-stage 1, then a clean run
    gen_pattern(4, 30);
    run_transform(4, 0, 2, 0, 1, 1, 1'b0, 1'b0);
    gen_pattern(4, 30);
    run_transform(4, 0, 2, 0, 1, -1, 1'b0, 1'b0);

    // oversized length clamps to the maximum
    gen_pattern(LMAX, 0);
    run_transform(15, 1, 5, 0, 0, -1, 1'b0, 1'b0);

    // randomized transforms, including L=0 clamp and threshold extremes
    for (int t = 0; t < 10; t++) begin
      l   = $urandom_range(0, 7);
      md  = $urandom_range(0, 1);
      th  = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 6);
      pct = $urandom_range(0, 50);
      gen_pattern(clamp_len(l), pct);
      run_transform(l, md, th, 0, 2, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("stage_queue_drained", 64'(exp_stage_q.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_bfp_scale_ctrl.md
Name: fft_bfp_scale_ctrl

Overview:
Block-floating-point scaling controller that sequences the per-sample rescale datapath across all stages of one FFT.
- Counts samples per stage and counts overflow flags returned by the rescale datapath.
- Decides whether the next stage is divided by 2.
- Accumulates the block exponent for the whole transform.
- Sits between the FFT stage sequencer and the rescale datapath; drives its rescale enable.

Parameters:
LOG2_N_MAX, 10, largest supported FFT size as log2 (1024 points); also width of the stage bitmap
SCALE_FACTOR_WIDTH, 8, width of block exponent output
STAGE_WIDTH, 4, width of stage index, must satisfy 2^STAGE_WIDTH > LOG2_N_MAX

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous, active-low
start_i  in  1  start transform; accepted only in IDLE
fft_len_log2_i  in  STAGE_WIDTH  log2 of FFT length L, sampled on accepted start
rescale_mode_i  in  1  0=conditional /2 on overflow, 1=unconditional /2 every stage (divide by N); sampled on start
threshold_i  in  8  overflow count in a stage that triggers scaling of next stage; sampled on start
sample_valid_i  in  1  one sample of current stage passes the datapath
overflow_i  in  1  datapath overflow flag for this sample; qualified by sample_valid_i
rescale_en_o  out  1  enable /2 scaling in datapath for current stage
stage_o  out  STAGE_WIDTH  current stage index
busy_o  out  1  high in RUN and EVAL
done_o  out  1  one-cycle pulse at end of transform
block_exp_o  out  SCALE_FACTOR_WIDTH  number of scaled stages so far
ovf_count_o  out  8  overflows counted in current stage, saturating
stage_scaled_o  out  LOG2_N_MAX  bit s set if stage s was scaled

Behaviour:
- Reset (async, any state): state=IDLE; every output 0; internal sample and overflow counters 0; latched config 0.
- Config clamping on start: L=0 -> 1; L>LOG2_N_MAX -> LOG2_N_MAX. threshold 0 -> 1.
- States: IDLE, RUN, EVAL, DONE.
- IDLE:
  - start_i=1 at edge t latches L, mode and threshold.
  - Clears block_exp_o, stage_scaled_o, ovf_count_o, stage_o and the sample counter.
  - Sets rescale_en_o=mode, so stage 0 is scaled only in mode 1.
  - Enters RUN at t+1; busy_o=1 from t+1.
- RUN:
  - Each sample_valid_i increments the sample counter.
  - overflow_i with sample_valid_i increments ovf_count_o; it saturates at 255.
  - Gaps (valid low) hold all state.
  - The valid that makes the count equal 2^L moves to EVAL on the next edge. That sample's overflow is counted.
- EVAL (exactly 1 cycle, busy_o=1):
  - If rescale_en_o=1: block_exp_o += 1, saturating at all-ones, and stage_scaled_o[stage_o] = 1.
  - If stage_o == L-1: go to DONE, rescale_en_o=0.
  - Otherwise:
    - stage_o += 1.
    - rescale_en_o = mode | (ovf_count_o >= threshold).
    - ovf_count_o and the sample counter are cleared.
    - Return to RUN.
- DONE: done_o=1 for this single cycle, busy_o=0; next state IDLE.
  - block_exp_o, stage_scaled_o, stage_o and ovf_count_o hold until the next accepted start.
- start_i outside IDLE is ignored; there is no restart mid-transform.
- sample_valid_i in IDLE, EVAL or DONE is ignored and not counted; upstream must stall during EVAL.
- Latency:
  - Last sample of a stage to new rescale_en_o: 2 edges (RUN->EVAL, EVAL->RUN).
  - Last sample of the final stage to done_o: 2 edges.
- Reset asserted mid-RUN returns to IDLE with all outputs 0 immediately (asynchronous).
- Counter widths: sample counter is LOG2_N_MAX+1 bits so 2^LOG2_N_MAX is representable.

Test Plan:
1. L=3, mode=1, 24 contiguous valids, no overflow -> rescale_en_o=1 all stages; block_exp_o=3, stage_scaled_o=0b111; done_o pulses 2 edges after 24th valid.
2. L=3, mode=0, threshold=2:
   - Stimulus: 1 overflow in stage 0, 2 in stage 1, 0 in stage 2.
   - Response: rescale_en_o = 0, 0, 1 across stages; block_exp_o=1; stage_scaled_o=0b100.
3. L=9, mode=0, threshold=0: 300 overflows in stage 0 -> ovf_count_o saturates at 255; stage 1 rescale_en_o=1 (threshold clamped to 1).
4. L=2, valid every third cycle, start_i pulsed during RUN -> start ignored; stage boundaries only after 4 counted valids; done once; block_exp_o=0 in mode 0 without overflow.
5. reset_n_i low mid-stage 1 of L=4 -> all outputs 0 asynchronously; a fresh start then runs cleanly to done_o.
6. fft_len_log2_i=15 with LOG2_N_MAX=10, mode=1 -> 10 stages, block_exp_o=10, stage_scaled_o=all ones.
